// File: rtl/mips_bus_pkg.sv
// -----------------------------------------------------------------------------
// mips_bus_pkg
// Shared definitions for the MIPS two-port Avalon bus arbiter:
//   - arb_state_e      : arbiter FSM encoding (IDLE / BUS / RESP)
//   - PORT_IFETCH/DATA : requester port indices (bit positions in grant vectors)
//   - MAX_WAIT_DEFAULT : default waitrequest timeout, in cycles
//   - WAIT_CNT_W       : wait counter width (covers MAX_WAIT up to 65535)
// -----------------------------------------------------------------------------
package mips_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int unsigned PORT_IFETCH      = 0;
    localparam int unsigned PORT_DATA        = 1;
    localparam int unsigned MAX_WAIT_DEFAULT = 255;
    localparam int unsigned WAIT_CNT_W       = 16;

endpackage

// File: rtl/mips_bus_arb_sel.sv
// -----------------------------------------------------------------------------
// mips_bus_arb_sel
// Combinational grant selection between the instruction-fetch port (bit 0)
// and the data port (bit 1).
// Configuration macro: MIPS_BUS_ARB_RR_EN
//   undefined : fixed priority, data port wins on simultaneous requests
//   defined   : round-robin, the port not granted last wins on a tie
// Ports:
//   i_valids[1:0]  requests, indexed by port number
//   i_last_grant   port number granted most recently
//   o_grant[1:0]   one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module mips_bus_arb_sel
    import mips_bus_pkg::*;
(
    input  logic [1:0] i_valids,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_valids[PORT_DATA] && i_valids[PORT_IFETCH]) begin
`ifdef MIPS_BUS_ARB_RR_EN
            // Tie: hand the bus to whichever port did not have it last.
            if (i_last_grant == 1'(PORT_DATA))
                o_grant[PORT_IFETCH] = 1'b1;
            else
                o_grant[PORT_DATA] = 1'b1;
`else
            o_grant[PORT_DATA] = 1'b1;
`endif
        end else begin
            o_grant = i_valids;
        end
    end

`ifndef MIPS_BUS_ARB_RR_EN
    // Last-grant history is irrelevant to fixed priority.
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
`endif

endmodule

// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
// Arbitrates an instruction-fetch port (port 0, i_*) and a data port
// (port 1, d_*) onto a single Avalon-MM master. One transaction at a time:
// IDLE latches the granted request, BUS drives it until waitrequest drops
// (or MAX_WAIT wait cycles elapse), RESP issues a one-cycle done pulse.
// Configuration macro: MIPS_BUS_ARB_RR_EN (round-robin grant when defined,
// fixed data-port priority otherwise).
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   i_valid/i_write/i_addr/i_wdata/i_byteenable   port 0 request
//   i_done/i_rdata/i_err          port 0 completion, read data, timeout flag
//   d_valid/d_write/d_addr/d_wdata/d_byteenable   port 1 request
//   d_done/d_rdata/d_err          port 1 completion, read data, timeout flag
//   address/write/read/writedata/byteenable       Avalon master (registered)
//   waitrequest/readdata          Avalon slave responses
//   busy                          high while a transaction is in flight
// -----------------------------------------------------------------------------
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_byteenable,
    output logic        i_done,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_valid,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy
);

    localparam logic [WAIT_CNT_W-1:0] LP_WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [1:0]            w_req;
    logic [1:0]            w_grant;
    logic                  w_last_grant;
    logic                  r_gnt_data;
    logic                  r_timeout;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  w_accept;
    logic                  w_timeout;

    // The done pulse is visible while we are already back in IDLE and the
    // requester still holds valid for that cycle; mask it so the finished
    // request is not granted a second time.
    assign w_req     = {d_valid & ~d_done, i_valid & ~i_done};
    assign w_accept  = (r_state == ST_BUS) && !waitrequest;
    assign w_timeout = (r_state == ST_BUS) && waitrequest && (r_wait_cnt == LP_WAIT_LAST);
    assign busy      = (r_state != ST_IDLE);

`ifdef MIPS_BUS_ARB_RR_EN
    // r_rr_ptr names the port favoured on the next tie.
    logic r_rr_ptr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rr_ptr <= 1'(PORT_DATA);
        else if (r_state == ST_IDLE && |w_req)
            r_rr_ptr <= w_grant[PORT_IFETCH];
    end
    assign w_last_grant = ~r_rr_ptr;
`else
    assign w_last_grant = 1'(PORT_IFETCH);
`endif

    mips_bus_arb_sel u_sel (
        .i_valids     (w_req),
        .i_last_grant (w_last_grant),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_req) w_state_nxt = ST_BUS;
            ST_BUS:  if (w_accept || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            address    <= '0;
            writedata  <= '0;
            byteenable <= 4'b0000;
            read       <= 1'b0;
            write      <= 1'b0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            i_err      <= 1'b0;
            d_err      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            r_gnt_data <= 1'b0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            i_err  <= 1'b0;
            d_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_gnt_data <= w_grant[PORT_DATA];
                        r_timeout  <= 1'b0;
                        r_wait_cnt <= '0;
                        if (w_grant[PORT_DATA]) begin
                            address    <= d_addr;
                            writedata  <= d_wdata;
                            byteenable <= d_byteenable;
                            write      <= d_write;
                            read       <= ~d_write;
                        end else begin
                            address    <= i_addr;
                            writedata  <= i_wdata;
                            byteenable <= i_byteenable;
                            write      <= i_write;
                            read       <= ~i_write;
                        end
                    end
                end
                ST_BUS: begin
                    if (w_accept) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (read) begin
                            if (r_gnt_data) d_rdata <= readdata;
                            else            i_rdata <= readdata;
                        end
                    end else if (w_timeout) begin
                        read      <= 1'b0;
                        write     <= 1'b0;
                        r_timeout <= 1'b1;
                        if (r_gnt_data) d_rdata <= '0;
                        else            i_rdata <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (r_gnt_data) begin
                        d_done <= 1'b1;
                        d_err  <= r_timeout;
                    end else begin
                        i_done <= 1'b1;
                        i_err  <= r_timeout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 255: maximum consecutive waitrequest cycles before a transaction is aborted; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 i_valid, i_write, i_addr[31:0], i_wdata[31:0], i_byteenable[3:0]  input  port 0 (instruction fetch) request; held stable until i_done.
REQ-005 i_done  output  1  port 0 completion pulse; i_rdata[31:0]  output  32  read data; i_err  output  1  timeout flag qualified by i_done.
REQ-006 d_valid, d_write, d_addr[31:0], d_wdata[31:0], d_byteenable[3:0]  input  port 1 (data) request; same hold rule.
REQ-007 d_done, d_rdata[31:0], d_err  output  port 1 responses, same meaning as port 0.
REQ-008 address[31:0], write, read, writedata[31:0], byteenable[3:0]  output  Avalon master; waitrequest, readdata[31:0]  input.
REQ-009 busy  output  1  high while a transaction occupies the bus.

Function
REQ-010 States: IDLE, BUS, RESP; encoding from shared package.
REQ-011 IDLE: if any valid is high, grant per REQ-015, latch the granted port's request into registers, go to BUS; else stay.
REQ-012 BUS: drive registered address/writedata/byteenable; read = !latched_write, write = latched_write; exactly one asserted; all Avalon outputs registered, never combinational from requester inputs.
REQ-013 BUS, waitrequest low: capture readdata (reads) into the granted port's rdata, deassert read/write on the next edge, go to RESP.
REQ-014 RESP: pulse granted port's done for exactly one cycle, then IDLE; the other port's done stays low.
REQ-015 Default grant: fixed priority, port 1 (data) wins on simultaneous valid.
REQ-016 Minimum latency: valid sampled in cycle N, read/write high in N+1, done in N+3 when waitrequest low in N+1.
REQ-017 Wait counter: cleared on entry to BUS, increments each BUS cycle with waitrequest high; on reaching MAX_WAIT go to RESP with err=1, rdata=0, read/write deasserted.
REQ-018 err is 0 for every normally completed transaction.
REQ-019 Write transactions leave the port's rdata unchanged.
REQ-020 A valid that drops before done is a protocol violation; the latched transaction still completes.
REQ-021 busy = (state != IDLE).
REQ-022 Requests arriving during BUS/RESP wait; no queueing beyond the held valid.

Reset
REQ-023 On rst low, immediately: state IDLE; read, write, done, err, busy 0; address, writedata, rdata 0; byteenable 4'b0000; wait counter 0; round-robin pointer to port 1.
REQ-024 Reset during BUS aborts the transaction with no done pulse; read/write fall asynchronously.
REQ-025 First grant no earlier than the first rising edge after rst deasserts.

Configuration
REQ-026 Macro MIPS_BUS_ARB_RR_EN: when defined, grant is round-robin (on simultaneous valid, the port not granted last wins; pointer updates on each grant).
REQ-027 Without MIPS_BUS_ARB_RR_EN, fixed priority per REQ-015; no pointer register present.

Structure
REQ-028 Package mips_bus_pkg holds the arbiter state enum, port index constants (PORT_IFETCH=0, PORT_DATA=1) and the MAX_WAIT default.
REQ-029 Grant selection (fixed/round-robin) lives in sub-module mips_bus_arb_sel: inputs valids, last-grant; output one-hot grant.

Verification
REQ-030 Single port-0 read, addr 32'hBFC00000, waitrequest 0, readdata 32'h24020005 -> read high one cycle, i_rdata=32'h24020005, i_done 3 cycles after i_valid, i_err 0.
REQ-031 Simultaneous i_valid and d_valid (d_write, addr 32'h1000, wdata 32'hDEADBEEF) -> data write first, then fetch; without macro data wins repeatedly; with MIPS_BUS_ARB_RR_EN grants alternate d,i,d,i.
REQ-032 Port 1 read with waitrequest high 4 cycles then low, readdata 32'hCAFEF00D -> read held 5 cycles, address stable, d_rdata=32'hCAFEF00D, d_done once.
REQ-033 MAX_WAIT=3, waitrequest stuck high -> read dropped after 3 wait cycles, d_done with d_err 1, d_rdata 0; next request proceeds normally.
REQ-034 rst low mid-BUS -> read/write/busy 0 without clock edge, no done pulse; after release, pending valid granted normally.
